pipe_adder_nb: RTL and testbench

PIPE_ADDER_NB -- requirements
Module: pipe_adder_nb

---
 rtl/pipe_adder_nb.sv | 120 ++++++++++++
 tb/tb_pipe_adder_nb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder_nb.sv
// pipe_adder_nb: carry-chunked pipelined adder/subtractor with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the aligned signed-overflow output ovf.
module pipe_adder_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSTG = WIDTH / CHUNK;

    logic r_rdy;
    logic w_stall;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = r_rdy && !w_stall;

    // keep in_ready low for the cycle in which reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy <= 1'b0;
        else        r_rdy <= 1'b1;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int WO = WIDTH - k * CHUNK;
        logic                   w_vi;
        logic                   w_ci;
        logic [WO-1:0]          w_ai;
        logic [WO-1:0]          w_bi;
        logic [CHUNK:0]         w_add;
        logic [(k+1)*CHUNK-1:0] w_s;
        logic                   r_v;
        logic                   r_c;
        logic [(k+1)*CHUNK-1:0] r_s;

        if (k == 0) begin : g_src
            assign w_vi = in_valid && in_ready;
            assign w_ai = a;
            assign w_bi = sub ? ~b : b;
            assign w_ci = sub | cin;
            assign w_s  = w_add[CHUNK-1:0];
        end else begin : g_src
            assign w_vi = g_stg[k-1].r_v;
            assign w_ai = g_stg[k-1].g_op.r_a;
            assign w_bi = g_stg[k-1].g_op.r_b;
            assign w_ci = g_stg[k-1].r_c;
            assign w_s  = {w_add[CHUNK-1:0], g_stg[k-1].r_s};
        end

        assign w_add = {1'b0, w_ai[CHUNK-1:0]} + {1'b0, w_bi[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_ci};

        // advance valid; result chunks and chunk carry move only with a valid word so bubbles leave them intact
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (!w_stall) begin
                r_v <= w_vi;
                if (w_vi) begin
                    r_c <= w_add[CHUNK];
                    r_s <= w_s;
                end
            end
        end

        if (k < NSTG - 1) begin : g_op
            logic [WO-CHUNK-1:0] r_a;
            logic [WO-CHUNK-1:0] r_b;

            // skew the not-yet-added upper operand chunks along with their word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall && w_vi) begin
                    r_a <= w_ai[WO-1:CHUNK];
                    r_b <= w_bi[WO-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].r_v;
    assign sum       = g_stg[NSTG-1].r_s;
    assign carry     = g_stg[NSTG-1].r_c;

`ifdef PIPE_ADDER_OVF_EN
    logic r_ovf;
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = g_stg[NSTG-1].w_ai[CHUNK-1];
    assign w_sb = g_stg[NSTG-1].w_bi[CHUNK-1];
    assign w_sr = g_stg[NSTG-1].w_add[CHUNK-1];

    // like-signed effective operands giving a result of the other sign overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_ovf <= 1'b0;
        else if (!w_stall && g_stg[NSTG-1].w_vi)   r_ovf <= (w_sa == w_sb) && (w_sr != w_sa);
    end

    assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipe_adder_nb.sv
// tb_pipe_adder_nb: scoreboard bench for pipe_adder_nb (WIDTH=16, CHUNK=4); ovf checked when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder_nb;
    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NS = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    logic         rdy_ok = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_acc = 0;
    int           n_ret = 0;
    logic [W+1:0] q[$];

    always #5 clk = ~clk;

    pipe_adder_nb #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .carry(carry)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // reference: {ovf, carry, sum} from whole-word arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   r;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | c};
        return {(x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]), r};
    endfunction

    // scoreboard: compare head while valid (also covers stall stability), pop on retire, push on accept
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_data", {47'd0, carry, sum}, 64'd0);
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_ok && !(out_valid && !out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious", {63'd0, out_valid}, 64'd0);
                end else begin
                    chk("result", {47'd0, carry, sum}, {47'd0, q[0][W:0]});
`ifdef PIPE_ADDER_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, q[0][W+1]});
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_ret++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                n_acc++;
            end
        end
    end

    task automatic do_reset(input int cyc);
        rst_n    = 1'b0;
        rdy_ok   = 1'b0;
        in_valid = 1'b0;
        repeat (cyc) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 rdy_ok = 1'b1;
    endtask

    task automatic one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs, input logic [W+1:0] exp);
        int n;
        a = xa; b = xb; cin = xc; sub = xs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 64'(n), 64'(NS));
        chk("dir_res", {47'd0, carry, sum}, {47'd0, exp[W:0]});
`ifdef PIPE_ADDER_OVF_EN
        chk("dir_ovf", {63'd0, ovf}, {63'd0, exp[W+1]});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        do_reset(3);
        one(16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
        one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 18'h1FFFF);
        one(16'h0000, 16'h0001, 1'b0, 1'b1, 18'h0FFFF);
        one(16'h1234, 16'h1234, 1'b0, 1'b1, 18'h10000);
        one(16'h0005, 16'h0003, 1'b1, 1'b1, 18'h10002);
`ifdef PIPE_ADDER_OVF_EN
        one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
        one(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
        one(16'h0001, 16'h0001, 1'b0, 1'b0, 18'h00002);
`endif
        r0 = n_ret;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (NS) @(posedge clk);
        #1;
        chk("b2b_count", 64'(n_ret - r0), 64'd1000);
        chk("b2b_left", 64'(q.size()), 64'd0);
        a0 = n_acc;
        r0 = n_ret;
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid  = 1'b1;
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("stall_drain");
        chk("no_loss", 64'(n_ret - r0), 64'(n_acc - a0));
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_flush", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        one(16'hA5A5, 16'h1111, 1'b1, 1'b0, 18'h0B6B7);
        drain("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
